// File: rtl/arb_pkg.sv
// Shared types for the grant mux: requester count, FSM states and the
// one-hot grant decoder used on both sides of the arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] idx;
  } oh_res_t;

  function automatic oh_res_t onehot_to_idx(
    input logic [NUM_REQ-1:0] oh
  );
    oh_res_t r;
    r.vld = 1'b0;
    r.idx = '0;
    case (oh)
      4'b0001: begin r.vld = 1'b1; r.idx = 2'd0; end
      4'b0010: begin r.vld = 1'b1; r.idx = 2'd1; end
      4'b0100: begin r.vld = 1'b1; r.idx = 2'd2; end
      4'b1000: begin r.vld = 1'b1; r.idx = 2'd3; end
      default: begin r.vld = 1'b0; r.idx = 2'd0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arb_grant_mux_if.sv
// Per-requester beat bundle plus the shared master port.
// master: the mux side; slave: requesters and sink.
interface arb_grant_mux_if
  import arb_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4
) ();

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ*LW-1:0] req_len;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  m_valid;
  logic [DW-1:0]         m_data;
  logic [ID_W-1:0]       m_id;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_len,
    output req_ready,
    output m_valid,
    output m_data,
    output m_id,
    output m_last,
    input  m_ready
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_len,
    input  req_ready,
    input  m_valid,
    input  m_data,
    input  m_id,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/arb_grant_mux_onehot_enc.sv
// 4-bit one-hot to index encoder; vld is low for zero or multi-hot input.
module onehot_enc
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] oh,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  oh_res_t res;

  always_comb begin
    res = onehot_to_idx(oh);
    idx = res.idx;
    vld = res.vld;
  end

endmodule

// File: rtl/arb_grant_mux.sv
// Locks a one-hot grant owner for a whole burst and muxes its handshake.
// ARB_GRANT_MUX_TIMEOUT_EN adds a stall watchdog and a timeout output.
module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
  ,
  parameter int TO_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] grant,
  arb_grant_mux_if.master    bus,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic               grant_err
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            gerr_q, gerr_d;

  logic [ID_W-1:0]    g_idx;
  logic               g_vld;
  logic               hs;
  logic               mv;
  logic [NUM_REQ-1:0] rr;

`ifdef ARB_GRANT_MUX_TIMEOUT_EN
  localparam int SW = $clog2(TO_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          to_q, to_d;
`endif

  onehot_enc u_enc (
    .oh  (grant),
    .idx (g_idx),
    .vld (g_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      gerr_q  <= 1'b0;
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
      stall_q <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gerr_q  <= gerr_d;
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
      stall_q <= stall_d;
      to_q    <= to_d;
`endif
    end
  end

  assign mv = bus.req_valid[owner_q];
  assign hs = (state_q == XFER) & mv & bus.m_ready;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gerr_d      = gerr_q;
    rr          = '0;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_id    = '0;
    bus.m_last  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    done_id     = '0;
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
    stall_d     = stall_q;
    to_d        = 1'b0;
    timeout     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
        stall_d = '0;
`endif
        if (g_vld) begin
          owner_d = g_idx;
          cnt_d   = bus.req_len[g_idx*LW +: LW];
          state_d = XFER;
        end else if (|grant) begin
          gerr_d = 1'b1;
        end
      end
      XFER: begin
        busy        = 1'b1;
        bus.m_valid = mv;
        bus.m_data  = bus.req_data[owner_q*DW +: DW];
        bus.m_id    = owner_q;
        bus.m_last  = (cnt_q == '0);
        rr[owner_q] = bus.m_ready;
        if (hs) begin
          if (cnt_q == '0) state_d = DONE;
          else cnt_d = cnt_q - 1'b1;
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_q == SW'(TO_CYCLES - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        done_id = owner_q;
        state_d = IDLE;
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
        timeout = to_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = rr;
  assign grant_err     = gerr_q;

endmodule
